// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
//
// Burst initiator for a single-port synchronous sram. Accepts CPU burst
// read/write requests, drives the sram address/data/write-enable from
// registers, and returns read data in order, one beat per cycle. This is the
// only block that drives the sram ports.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   req_valid  burst request valid
//   req_ready  controller idle and able to accept a request
//   req_we     1 = write burst, 0 = read burst
//   req_addr   burst start address (wraps modulo 2**ADDR_WIDTH)
//   req_len    number of beats (0 is treated as 1)
//   wr_valid   write beat data valid
//   wr_ready   write beat accepted when wr_valid & wr_ready
//   wr_data    write beat data
//   rd_valid   read beat valid, one cycle per beat, no backpressure
//   rd_data    read beat data
//   busy       burst in progress
//   done       one-cycle pulse when a burst completes
//   mem_addr   sram address (registered)
//   mem_wdata  sram write data (registered)
//   mem_we     sram write enable (registered)
//   mem_rdata  sram read data, valid one cycle after the address is sampled
// ---------------------------------------------------------------------------
module sram_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_WIDTH = 16,
    parameter int LEN_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [WORD_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [WORD_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    // Read-return pipeline: pend1 marks an address just registered to the
    // sram, pend2 marks that the sram has sampled it and mem_rdata is valid.
    logic                  rd_pend1_q, rd_pend1_d;
    logic                  rd_pend2_q, rd_pend2_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  done_q, done_d;

    logic                  wr_fire;
    logic                  last_beat;

    assign wr_fire   = wr_valid & wr_ready;
    assign last_beat = (beat_cnt_q == LEN_WIDTH'(1));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_cnt_q  <= '0;
            beat_cnt_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rd_pend1_q  <= 1'b0;
            rd_pend2_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_cnt_q  <= addr_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            rd_pend1_q  <= rd_pend1_d;
            rd_pend2_q  <= rd_pend2_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = req_we ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (wr_fire && last_beat) begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (last_beat) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // With pend1 clear, the last beat sits in pend2 and returns
                // on this edge.
                if (!rd_pend1_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        addr_cnt_d  = addr_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        rd_pend1_d  = 1'b0;
        rd_pend2_d  = rd_pend1_q;
        rd_valid_d  = rd_pend2_q;
        rd_data_d   = rd_pend2_q ? mem_rdata : rd_data_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_cnt_d = req_addr;
                    beat_cnt_d = (req_len == '0) ? LEN_WIDTH'(1) : req_len;
                end
            end
            S_WRITE: begin
                // A cycle without a beat leaves mem_we low (bubble).
                if (wr_fire) begin
                    mem_addr_d  = addr_cnt_q;
                    mem_wdata_d = wr_data;
                    mem_we_d    = 1'b1;
                    addr_cnt_d  = addr_cnt_q + ADDR_WIDTH'(1);
                    beat_cnt_d  = beat_cnt_q - LEN_WIDTH'(1);
                    done_d      = last_beat;
                end
            end
            S_READ: begin
                mem_addr_d = addr_cnt_q;
                rd_pend1_d = 1'b1;
                addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
                beat_cnt_d = beat_cnt_q - LEN_WIDTH'(1);
            end
            S_DRAIN: begin
                done_d = !rd_pend1_q;
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready = (state_q == S_IDLE);
        wr_ready  = (state_q == S_WRITE);
        busy      = (state_q != S_IDLE);
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sram_ctrl.sv
module tb_sram_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [11:0] req_addr;
    logic [4:0]  req_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    sram_ctrl #(.ADDR_WIDTH(12), .WORD_WIDTH(16), .LEN_WIDTH(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous sram, read-first, one cycle read latency.
    logic [15:0] mem [4096];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [4:0]  len;
        logic [15:0] d0;
        logic [15:0] step;
        int          beats;
        logic [11:0] last_addr;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input vec_t v, input string tag);
        int          sent;
        int          nbeat;
        int          ndone;
        int          first_c;
        logic [11:0] a;
        logic [15:0] d;
        logic [15:0] wd;
        logic        acc;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_len   = v.len;
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        sent = 0; nbeat = 0; ndone = 0; first_c = -1;
        a = v.addr; d = v.d0; wd = v.d0;
        for (int c = 0; c < 40 && ndone == 0; c++) begin
            wr_valid = v.we && (sent < v.beats);
            wr_data  = wd;
            acc      = wr_valid & wr_ready;
            @(posedge clk);
            if (acc) begin
                sent++;
                wd = wd + v.step;
            end
            @(negedge clk);
            if (v.we ? mem_we : rd_valid) begin
                if (first_c < 0) first_c = c;
                if (v.we) begin
                    check({tag, "_mem_addr"}, 32'(mem_addr), 32'(a));
                    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(d));
                end else begin
                    check({tag, "_rd_data"}, 32'(rd_data), 32'(d));
                end
                a = a + 12'd1;
                d = d + v.step;
                nbeat++;
            end
            if (done) begin
                ndone++;
                check({tag, "_done_with_beat"}, 32'(v.we ? mem_we : rd_valid), 32'd1);
                check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            end
        end
        wr_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            if (mem_we || rd_valid) nbeat++;
            if (done) ndone++;
        end
        check({tag, "_beats"}, 32'(nbeat), 32'(v.beats));
        check({tag, "_done_count"}, 32'(ndone), 32'd1);
        check({tag, "_first_beat_cycle"}, 32'(first_c), v.we ? 32'd0 : 32'd2);
        check({tag, "_last_addr"}, 32'(a - 12'd1), 32'(v.last_addr));
    endtask

    initial begin
        int          sent;
        int          nwr;
        int          done_c;
        int          nrd;
        int          ndone;
        logic        acc;
        logic [15:0] gap_we;
        vec_t        rb;

        vecs[0] = '{we: 1'b1, addr: 12'h010, len: 5'd4, d0: 16'hA000, step: 16'h0001, beats: 4, last_addr: 12'h013};
        vecs[1] = '{we: 1'b0, addr: 12'h010, len: 5'd4, d0: 16'hA000, step: 16'h0001, beats: 4, last_addr: 12'h013};
        vecs[2] = '{we: 1'b1, addr: 12'hFFF, len: 5'd2, d0: 16'h1111, step: 16'h1111, beats: 2, last_addr: 12'h000};
        vecs[3] = '{we: 1'b0, addr: 12'hFFF, len: 5'd2, d0: 16'h1111, step: 16'h1111, beats: 2, last_addr: 12'h000};
        vecs[4] = '{we: 1'b1, addr: 12'h020, len: 5'd0, d0: 16'h5A5A, step: 16'h0000, beats: 1, last_addr: 12'h020};
        vecs[5] = '{we: 1'b0, addr: 12'h020, len: 5'd0, d0: 16'h5A5A, step: 16'h0000, beats: 1, last_addr: 12'h020};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
        wr_valid = 1'b0; wr_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Write len=3 at 0x040 with a wr_valid gap after the first beat
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h040; req_len = 5'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        sent = 0; nwr = 0; done_c = -1; gap_we = '0;
        for (int c = 0; c < 6; c++) begin
            wr_valid = (c != 1) && (sent < 3);
            wr_data  = 16'hB000 + 16'(sent);
            acc      = wr_valid & wr_ready;
            @(posedge clk);
            if (acc) sent++;
            @(negedge clk);
            gap_we[c] = mem_we;
            if (mem_we) begin
                check("gap_mem_addr", 32'(mem_addr), 32'(12'h040 + 12'(nwr)));
                check("gap_mem_wdata", 32'(mem_wdata), 32'(16'hB000 + 16'(nwr)));
                nwr++;
            end
            if (done) done_c = c;
        end
        wr_valid = 1'b0;
        check("gap_writes", 32'(nwr), 32'd3);
        check("gap_we_pattern", 32'(gap_we[5:0]), 32'b001101);
        check("gap_done_cycle", 32'(done_c), 32'd3);
        rb = '{we: 1'b0, addr: 12'h040, len: 5'd3, d0: 16'hB000, step: 16'h0001, beats: 3, last_addr: 12'h042};
        run_vec(rb, "gap_rb");

        // len=0 read with req_valid held for the whole burst
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h020; req_len = 5'd0;
        nrd = 0; ndone = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (!busy) req_valid = 1'b0;
            if (rd_valid) begin
                check("hold_rd_data", 32'(rd_data), 32'h5A5A);
                nrd++;
            end
            if (done) ndone++;
        end
        check("hold_rd_count", 32'(nrd), 32'd1);
        check("hold_done_count", 32'(ndone), 32'd1);
        check("hold_req_ready", 32'(req_ready), 32'd1);

        // Reset in the middle of a len=8 read after three issues
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h010; req_len = 5'd8;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("abort_beat0_valid", 32'(rd_valid), 32'd1);
        check("abort_beat0_data", 32'(rd_data), 32'hA000);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rd_valid", 32'(rd_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        nrd = 0; ndone = 0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
            if (rd_valid) nrd++;
            if (done || busy) ndone++;
        end
        check("abort_no_rd", 32'(nrd), 32'd0);
        check("abort_no_done", 32'(ndone), 32'd0);

        // Controller usable again after the abort
        rb = '{we: 1'b0, addr: 12'h010, len: 5'd1, d0: 16'hA000, step: 16'h0001, beats: 1, last_addr: 12'h010};
        run_vec(rb, "post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
